// File: rtl/line_buffer_scheduler_pkg.sv
// Shared CNN definitions for the line-buffer scheduler: address width,
// scheduler state encoding and a counter-width helper.
package line_buffer_scheduler_pkg;

    localparam int unsigned ADDR_WIDTH = 14;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_STALL = 1'b1
    } sched_state_e;

    // Counter width for a modulo-n counter, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/line_buffer_scheduler_bank_tracker.sv
// bank_tracker: per-bank full flags and reader hand-off for the ping-pong
// line buffer.
//   clk, reset        : clock, asynchronous active-high reset
//   fill, fill_bank   : one-cycle pulse, bank fill_bank has just been filled
//   rd_done           : one-cycle pulse, reader finished rd_bank
//   bank_full         : per-bank full flags
//   rd_start, rd_bank : one-cycle offer pulse and the bank handed to the reader
module bank_tracker (
    input  logic       clk,
    input  logic       reset,
    input  logic       fill,
    input  logic       fill_bank,
    input  logic       rd_done,
    output logic [1:0] bank_full,
    output logic       rd_start,
    output logic       rd_bank
);

    logic [1:0] bank_full_q, bank_full_d;
    logic       rd_start_q, rd_start_d;
    logic       rd_bank_q, rd_bank_d;
    logic       busy_q, busy_d;

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_full_q <= 2'b00;
            rd_start_q  <= 1'b0;
            rd_bank_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            bank_full_q <= bank_full_d;
            rd_start_q  <= rd_start_d;
            rd_bank_q   <= rd_bank_d;
            busy_q      <= busy_d;
        end
    end

    // Banks are read strictly in fill order, so the next bank to offer is
    // simply the other one once the current read completes.
    always_comb begin
        bank_full_d = bank_full_q;
        rd_start_d  = 1'b0;
        rd_bank_d   = rd_bank_q;
        busy_d      = busy_q;

        if (fill) begin
            bank_full_d[fill_bank] = 1'b1;
        end

        if (busy_q && rd_done) begin
            bank_full_d[rd_bank_q] = 1'b0;
            rd_bank_d              = ~rd_bank_q;
            busy_d                 = 1'b0;
        end else if (!busy_q && bank_full_q[rd_bank_q]) begin
            rd_start_d = 1'b1;
            busy_d     = 1'b1;
        end
    end

    assign bank_full = bank_full_q;
    assign rd_start  = rd_start_q;
    assign rd_bank   = rd_bank_q;

endmodule

// File: rtl/line_buffer_scheduler.sv
// line_buffer_scheduler: accepts a pixel stream and schedules writes into a
// ping-pong pair of line-buffer banks, handing full banks to a reader.
//   clk, reset          : clock, asynchronous active-high reset
//   pix_valid/pix_data  : upstream pixel stream, pix_ready accepts it
//   we/wr_addr/data_out : registered line-buffer write port
//   eol                 : high with the write of the last column of a line
//   wr_bank             : bank currently being written
//   rd_start/rd_bank    : offer pulse and bank handed to the reader
//   rd_done             : reader finished rd_bank
//   bank_full           : per-bank full flags
module line_buffer_scheduler
    import line_buffer_scheduler_pkg::*;
#(
    parameter int unsigned NUM_LINES  = 3,
    parameter int unsigned LINE_WIDTH = 64,
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    input  logic [DATA_WIDTH-1:0] pix_data,
    output logic                  pix_ready,
    output logic                  we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  eol,
    output logic                  wr_bank,
    output logic                  rd_start,
    output logic                  rd_bank,
    input  logic                  rd_done,
    output logic [1:0]            bank_full
);

    localparam int unsigned LINE_CNT_W = cnt_width(NUM_LINES);
    localparam logic [ADDR_WIDTH-1:0] LAST_COL  = ADDR_WIDTH'(LINE_WIDTH - 1);
    localparam logic [LINE_CNT_W-1:0] LAST_LINE = LINE_CNT_W'(NUM_LINES - 1);

    sched_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] col_q, col_d;
    logic [LINE_CNT_W-1:0] line_q, line_d;
    logic                  wr_bank_q, wr_bank_d;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  eol_q, eol_d;
    logic                  bank_done_q, bank_done_d;

    logic accept;
    logic last_col;
    logic last_line;
    logic other_bank;

    assign pix_ready  = (state_q == ST_FILL) && !bank_full[wr_bank_q];
    assign accept     = pix_valid && pix_ready;
    assign last_col   = (col_q == LAST_COL);
    assign last_line  = (line_q == LAST_LINE);
    assign other_bank = ~wr_bank_q;

    // State registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_FILL;
            col_q       <= '0;
            line_q      <= '0;
            wr_bank_q   <= 1'b0;
            we_q        <= 1'b0;
            wr_addr_q   <= '0;
            data_out_q  <= '0;
            eol_q       <= 1'b0;
            bank_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            line_q      <= line_d;
            wr_bank_q   <= wr_bank_d;
            we_q        <= we_d;
            wr_addr_q   <= wr_addr_d;
            data_out_q  <= data_out_d;
            eol_q       <= eol_d;
            bank_done_q <= bank_done_d;
        end
    end

    // Column/line counting on accept, write-port register, FSM next state.
    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        line_d      = line_q;
        wr_bank_d   = wr_bank_q;
        we_d        = 1'b0;
        wr_addr_d   = wr_addr_q;
        data_out_d  = data_out_q;
        eol_d       = 1'b0;
        bank_done_d = 1'b0;

        if (accept) begin
            we_d       = 1'b1;
            wr_addr_d  = col_q;
            data_out_d = pix_data;
            if (last_col) begin
                col_d = '0;
                eol_d = 1'b1;
                if (last_line) begin
                    line_d      = '0;
                    bank_done_d = 1'b1;
                end else begin
                    line_d = line_q + LINE_CNT_W'(1);
                end
            end else begin
                col_d = col_q + ADDR_WIDTH'(1);
            end
        end

        // bank_done_q coincides with the closing eol; switch banks after it.
        if (bank_done_q) begin
            wr_bank_d = other_bank;
        end

        case (state_q)
            ST_FILL: begin
                // Stall right after the bank-closing accept if the next bank
                // is still held by the reader, so no pixel is taken for it.
                if ((accept && last_col && last_line && bank_full[other_bank]) ||
                    bank_full[wr_bank_q]) begin
                    state_d = ST_STALL;
                end
            end
            ST_STALL: begin
                // Wait out the bank switch, then for the target bank to drain.
                if (!bank_full[wr_bank_q] && !bank_done_q) begin
                    state_d = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    bank_tracker u_bank_tracker (
        .clk       (clk),
        .reset     (reset),
        .fill      (bank_done_q),
        .fill_bank (wr_bank_q),
        .rd_done   (rd_done),
        .bank_full (bank_full),
        .rd_start  (rd_start),
        .rd_bank   (rd_bank)
    );

    assign we       = we_q;
    assign wr_addr  = wr_addr_q;
    assign data_out = data_out_q;
    assign eol      = eol_q;
    assign wr_bank  = wr_bank_q;

endmodule

// File: tb/tb_line_buffer_scheduler.sv
// Directed testbench for line_buffer_scheduler with NUM_LINES=3, LINE_WIDTH=4.
module tb_line_buffer_scheduler;

    localparam int unsigned NL = 3;
    localparam int unsigned LW = 4;
    localparam int unsigned DW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          pix_valid;
    logic [DW-1:0] pix_data;
    logic          pix_ready;
    logic          we;
    logic [13:0]   wr_addr;
    logic [DW-1:0] data_out;
    logic          eol;
    logic          wr_bank;
    logic          rd_start;
    logic          rd_bank;
    logic          rd_done;
    logic [1:0]    bank_full;

    int n_checks = 0;
    int n_fail   = 0;

    line_buffer_scheduler #(
        .NUM_LINES  (NL),
        .LINE_WIDTH (LW),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .we        (we),
        .wr_addr   (wr_addr),
        .data_out  (data_out),
        .eol       (eol),
        .wr_bank   (wr_bank),
        .rd_start  (rd_start),
        .rd_bank   (rd_bank),
        .rd_done   (rd_done),
        .bank_full (bank_full)
    );

    always #5 clk = ~clk;

    // One cycle: inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_data  = '0;
        rd_done   = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        pix_valid = 1'b0;
        pix_data  = 16'hFFFF;
        rd_done   = 1'b0;
        #3;
        n_checks++;
        if ({we, eol, rd_start, wr_bank, rd_bank, bank_full} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b want 0000000",
                     {we, eol, rd_start, wr_bank, rd_bank, bank_full});
        end
        n_checks++;
        if ({wr_addr, data_out} !== 30'h0) begin
            n_fail++;
            $display("FAIL reset_addr_data: got addr %h data %h want 0 0", wr_addr, data_out);
        end
        n_checks++;
        if (pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_pix_ready: got %b want 1", pix_ready);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        n_checks++;
        if ({pix_ready, we} !== 2'b10) begin
            n_fail++;
            $display("FAIL reset_release: got ready,we %b want 10", {pix_ready, we});
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'(100 + i);
            n_checks++;
            if (pix_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_ready[%0d]: got %b want 1", i, pix_ready);
            end
            step();
            n_checks++;
            if ({we, eol, wr_bank, rd_start, bank_full, wr_addr, data_out} !==
                {1'b1, (i % 4 == 3), 1'b0, 1'b0, 2'b00, 14'(i % 4), 16'(100 + i)}) begin
                n_fail++;
                $display("FAIL b2b_write[%0d]: got we%b eol%b bank%b rs%b bf%b addr%0d data%0d want addr%0d data%0d eol%b",
                         i, we, eol, wr_bank, rd_start, bank_full, wr_addr, data_out,
                         i % 4, 100 + i, (i % 4 == 3));
            end
        end
        pix_valid = 1'b0;
        step();
        n_checks++;
        if ({we, rd_start, wr_bank, bank_full} !== 5'b00101) begin
            n_fail++;
            $display("FAIL b2b_bank_switch: got we,rs,wb,bf %b want 00101",
                     {we, rd_start, wr_bank, bank_full});
        end
        step();
        n_checks++;
        if ({rd_start, rd_bank, bank_full} !== 4'b1001) begin
            n_fail++;
            $display("FAIL b2b_rd_start: got rs,rb,bf %b want 1001", {rd_start, rd_bank, bank_full});
        end
        for (int k = 0; k < 4; k++) begin
            step();
            n_checks++;
            if (rd_start !== 1'b0) begin
                n_fail++;
                $display("FAIL b2b_rd_start_once[%0d]: got %b want 0", k, rd_start);
            end
        end
    endtask

    task automatic test_fill_both();
        do_reset();
        for (int i = 0; i < 24; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'(200 + i);
            n_checks++;
            if (pix_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL fill_ready[%0d]: got %b want 1", i, pix_ready);
            end
            step();
            n_checks++;
            if ({we, eol, wr_bank, rd_start, bank_full, wr_addr, data_out} !==
                {1'b1, (i % 4 == 3), 1'(i / 12), (i == 13), ((i >= 12) ? 2'b01 : 2'b00),
                 14'(i % 4), 16'(200 + i)}) begin
                n_fail++;
                $display("FAIL fill_write[%0d]: got we%b eol%b bank%b rs%b bf%b addr%0d data%0d",
                         i, we, eol, wr_bank, rd_start, bank_full, wr_addr, data_out);
            end
        end
        pix_valid = 1'b1;
        pix_data  = 16'h0500;
        n_checks++;
        if (pix_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL fill_ready_after_24: got %b want 0", pix_ready);
        end
        for (int k = 0; k < 8; k++) begin
            step();
            n_checks++;
            if ({we, pix_ready, bank_full, wr_bank} !== 5'b00110) begin
                n_fail++;
                $display("FAIL fill_held[%0d]: got we,ready,bf,wb %b want 00110",
                         k, {we, pix_ready, bank_full, wr_bank});
            end
        end
    endtask

    // Continues from the both-banks-full state left by test_fill_both.
    task automatic test_rd_done_both_full();
        n_checks++;
        if ({rd_bank, rd_start} !== 2'b00) begin
            n_fail++;
            $display("FAIL both_pre: got rb,rs %b want 00", {rd_bank, rd_start});
        end
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        n_checks++;
        if ({bank_full, pix_ready, rd_start, we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL both_clear: got bf,ready,rs,we %b want 10000",
                     {bank_full, pix_ready, rd_start, we});
        end
        step();
        n_checks++;
        if ({rd_start, rd_bank, pix_ready, bank_full} !== 5'b11110) begin
            n_fail++;
            $display("FAIL both_restart: got rs,rb,ready,bf %b want 11110",
                     {rd_start, rd_bank, pix_ready, bank_full});
        end
        step();
        pix_valid = 1'b0;
        n_checks++;
        if ({we, eol, wr_bank, rd_start, wr_addr, data_out} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 14'd0, 16'h0500}) begin
            n_fail++;
            $display("FAIL both_held_pixel: got we%b eol%b wb%b rs%b addr%0d data%h want 1 0 0 0 0 0500",
                     we, eol, wr_bank, rd_start, wr_addr, data_out);
        end
    endtask

    task automatic test_done_with_fill();
        int we_cnt;
        we_cnt = 0;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'(300 + i);
            step();
            if (we === 1'b1) we_cnt++;
        end
        n_checks++;
        if ({eol, wr_addr, data_out} !== {1'b1, 14'd3, 16'(323)}) begin
            n_fail++;
            $display("FAIL dwf_eol24: got eol%b addr%0d data%0d want 1 3 323", eol, wr_addr, data_out);
        end
        rd_done   = 1'b1;
        pix_valid = 1'b1;
        pix_data  = 16'h0600;
        n_checks++;
        if ({pix_ready, rd_bank} !== 2'b00) begin
            n_fail++;
            $display("FAIL dwf_pre: got ready,rb %b want 00", {pix_ready, rd_bank});
        end
        step();
        rd_done = 1'b0;
        if (we === 1'b1) we_cnt++;
        n_checks++;
        if ({bank_full, rd_start, pix_ready, we} !== 5'b10000) begin
            n_fail++;
            $display("FAIL dwf_flags: got bf,rs,ready,we %b want 10000",
                     {bank_full, rd_start, pix_ready, we});
        end
        step();
        if (we === 1'b1) we_cnt++;
        n_checks++;
        if ({rd_start, rd_bank, pix_ready} !== 3'b111) begin
            n_fail++;
            $display("FAIL dwf_rd_start: got rs,rb,ready %b want 111", {rd_start, rd_bank, pix_ready});
        end
        step();
        pix_valid = 1'b0;
        if (we === 1'b1) we_cnt++;
        n_checks++;
        if ({we, wr_bank, wr_addr, data_out} !== {1'b1, 1'b0, 14'd0, 16'h0600}) begin
            n_fail++;
            $display("FAIL dwf_next_pixel: got we%b wb%b addr%0d data%h want 1 0 0 0600",
                     we, wr_bank, wr_addr, data_out);
        end
        for (int k = 0; k < 3; k++) begin
            step();
            if (we === 1'b1) we_cnt++;
        end
        n_checks++;
        if (we_cnt !== 25 || bank_full !== 2'b10) begin
            n_fail++;
            $display("FAIL dwf_count: got writes %0d bf %b want 25 10", we_cnt, bank_full);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 6; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'(400 + i);
            step();
        end
        pix_valid = 1'b0;
        n_checks++;
        if ({we, wr_addr} !== {1'b1, 14'd1}) begin
            n_fail++;
            $display("FAIL mid_pre: got we%b addr%0d want 1 1", we, wr_addr);
        end
        reset = 1'b1;
        #1;
        n_checks++;
        if ({we, eol, rd_start, wr_bank, rd_bank, bank_full, pix_ready} !== 8'b00000001) begin
            n_fail++;
            $display("FAIL mid_reset_flags: got %b want 00000001",
                     {we, eol, rd_start, wr_bank, rd_bank, bank_full, pix_ready});
        end
        n_checks++;
        if ({wr_addr, data_out} !== 30'h0) begin
            n_fail++;
            $display("FAIL mid_reset_addr_data: got addr %h data %h want 0 0", wr_addr, data_out);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'(16'h0700 + i);
            step();
            n_checks++;
            if ({we, eol, wr_bank, wr_addr, data_out} !==
                {1'b1, (i == 3), 1'b0, 14'(i), 16'(16'h0700 + i)}) begin
                n_fail++;
                $display("FAIL mid_after[%0d]: got we%b eol%b wb%b addr%0d data%h",
                         i, we, eol, wr_bank, wr_addr, data_out);
            end
        end
        pix_valid = 1'b0;
        step();
        n_checks++;
        if ({we, bank_full} !== 3'b000) begin
            n_fail++;
            $display("FAIL mid_no_fill: got we,bf %b want 000", {we, bank_full});
        end
    endtask

    task automatic test_toggle_valid();
        int  j;
        logic acc;
        j = 0;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            pix_valid = (c % 2 == 0);
            pix_data  = 16'(16'h0800 + c);
            acc       = pix_valid;
            step();
            n_checks++;
            if (we !== acc) begin
                n_fail++;
                $display("FAIL toggle_we[%0d]: got %b want %b", c, we, acc);
            end
            if (acc) begin
                n_checks++;
                if ({wr_addr, eol, data_out} !== {14'(j % 4), (j % 4 == 3), 16'(16'h0800 + c)}) begin
                    n_fail++;
                    $display("FAIL toggle_write[%0d]: got addr%0d eol%b data%h want addr%0d",
                             c, wr_addr, eol, data_out, j % 4);
                end
                j++;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic test_spurious_done();
        do_reset();
        rd_done = 1'b1;
        step();
        rd_done = 1'b0;
        n_checks++;
        if ({bank_full, rd_start, rd_bank} !== 4'b0000) begin
            n_fail++;
            $display("FAIL spurious_done: got bf,rs,rb %b want 0000", {bank_full, rd_start, rd_bank});
        end
        for (int i = 0; i < 12; i++) begin
            pix_valid = 1'b1;
            pix_data  = 16'(900 + i);
            step();
        end
        pix_valid = 1'b0;
        step();
        step();
        n_checks++;
        if ({rd_start, rd_bank, bank_full} !== 4'b1001) begin
            n_fail++;
            $display("FAIL spurious_then_fill: got rs,rb,bf %b want 1001", {rd_start, rd_bank, bank_full});
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_fill_both();
        test_rd_done_both_full();
        test_done_with_fill();
        test_reset_mid();
        test_toggle_valid();
        test_spurious_done();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/line_buffer_scheduler.md
LINE_BUFFER_SCHEDULER -- requirements
Module: line_buffer_scheduler

Interface
REQ-001 SHALL have parameter NUM_LINES, default 3, lines per ping-pong bank.
REQ-002 SHALL have parameter LINE_WIDTH, default 64, pixels per line, legal range 2..16384.
REQ-003 SHALL have parameter DATA_WIDTH, default 16, pixel width.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic rising-edge.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port pix_valid, input, 1, upstream pixel valid.
REQ-007 SHALL have port pix_data, input, DATA_WIDTH, upstream pixel.
REQ-008 SHALL have port pix_ready, output, 1, scheduler accepts pixel this cycle.
REQ-009 SHALL have port we, output, 1, line-buffer write enable.
REQ-010 SHALL have port wr_addr, output, 14, column address within current line.
REQ-011 SHALL have port data_out, output, DATA_WIDTH, pixel to line buffer.
REQ-012 SHALL have port eol, output, 1, end-of-line strobe.
REQ-013 SHALL have port wr_bank, output, 1, bank being written.
REQ-014 SHALL have port rd_start, output, 1, one-cycle pulse: bank rd_bank full, convolution may start.
REQ-015 SHALL have port rd_bank, output, 1, bank handed to reader.
REQ-016 SHALL have port rd_done, input, 1, one-cycle pulse: reader finished rd_bank.
REQ-017 SHALL have port bank_full, output, 2, per-bank full flag.

Function
REQ-018 Handshake: pixel transfers when pix_valid and pix_ready both high on a rising edge; pix_data is not held while pix_ready is low.
REQ-019 pix_ready SHALL be high iff state is FILL and bank_full[wr_bank] is 0.
REQ-020 Latency: an accepted pixel SHALL appear as we=1, data_out, wr_addr exactly one cycle later (registered); otherwise we=0.
REQ-021 wr_addr SHALL count 0..LINE_WIDTH-1 per accepted pixel and wrap to 0.
REQ-022 eol SHALL be 1 in the same cycle as the write with wr_addr=LINE_WIDTH-1, else 0.
REQ-023 Line counter SHALL count eols 0..NUM_LINES-1; on the eol with count NUM_LINES-1 it wraps to 0, sets bank_full[wr_bank], and toggles wr_bank in the following cycle.
REQ-024 States: FILL (accepting) and STALL (target bank full); FILL->STALL when the bank just selected is full; STALL->FILL in the cycle after that bank's flag clears.
REQ-025 Reader side: a full bank SHALL be offered via rd_start (one-cycle) with rd_bank set; only one bank is outstanding; rd_bank holds until rd_done.
REQ-026 rd_done SHALL clear bank_full[rd_bank] next cycle; if the other bank is full, rd_start for it SHALL pulse in the cycle after clearing.
REQ-027 rd_done while no bank is outstanding SHALL be ignored.
REQ-028 Simultaneous bank fill and rd_done on the other bank SHALL both take effect; no pixel is lost or duplicated.
REQ-029 Banks SHALL be offered to the reader in fill order, starting with bank 0.

Reset
REQ-030 reset SHALL asynchronously force: state FILL, wr_addr 0, line counter 0, wr_bank 0, rd_bank 0, bank_full 2'b00, we 0, eol 0, rd_start 0, data_out 0, no outstanding read.
REQ-031 reset mid-line or mid-read SHALL discard partial lines and outstanding reads; first pixel after release writes bank 0, address 0.

Structure
REQ-032 ADDR_WIDTH (14) and the FILL/STALL state encoding SHALL live in the shared CNN package.
REQ-033 One sub-module SHALL be used: bank_tracker (per-bank full flags, reader hand-off, rd_start generation); address/line counting stays in the top.

Verification (NUM_LINES=3, LINE_WIDTH=4)
REQ-034 Reset then 12 back-to-back pixels -> wr_addr 0,1,2,3 x3, eol on writes 4/8/12, bank_full=01, rd_start once with rd_bank=0.
REQ-035 24 pixels, no rd_done -> bank_full=11, pix_ready=0 from the cycle after the 24th accept; 25th pixel held until rd_done.
REQ-036 rd_done while both full -> bank_full[0] clears next cycle, rd_start with rd_bank=1 one cycle later, pix_ready returns high.
REQ-037 rd_done in the same cycle as the 24th write's eol -> bank_full ends 10, rd_start rd_bank=1 follows, pixel count exact.
REQ-038 reset asserted after 6 pixels -> all outputs at REQ-030 values immediately; next pixel writes bank 0, wr_addr 0.
REQ-039 pix_valid toggling 1,0,1,0 -> wr_addr advances only on accepted pixels; we never high without a preceding accept.
